// File: rtl/bitslip_align_pkg.sv
// bitslip_align_pkg
//   Shared definitions for the bitslip word aligner:
//     state_t            - aligner FSM state encoding
//     TRAIN_PATTERN_DEF  - default training word (8'hF0)
//     CNT_W              - width of the settle/match/miss counters
package bitslip_align_pkg;

    localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hF0;
    localparam int         CNT_W             = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CHECK  = 3'd2,
        SLIP   = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } state_t;

endpackage

// File: rtl/bitslip_align.sv
// bitslip_align
//   Word aligner for a serdes deserializer. It pulses BITSLIP to the upstream
//   deserializer one slip at a time, waits for the data to settle, and looks
//   for MATCH_COUNT consecutive copies of TRAIN_PATTERN. After eight fruitless
//   slip positions it flags fail_o and keeps scanning.
//
//   Optional feature: define BITSLIP_ALIGN_LOCK_MON_EN to keep watching the
//   data while locked; MISS_LIMIT consecutive mismatches drop lock and slip.
//   Without it, LOCKED is held until realign_i or reset.
//
//   Ports
//     CLKDIV      in   divided word clock (sole clock)
//     RST_N       in   synchronous active-low reset
//     data_i      in   [7:0] parallel word from the deserializer
//     realign_i   in   one-cycle request to restart alignment
//     bitslip_o   out  one-cycle pulse to the deserializer BITSLIP input
//     data_o      out  [7:0] data_i delayed by one cycle
//     valid_o     out  data_o is word-aligned
//     locked_o    out  alignment achieved
//     fail_o      out  sticky: eight slip positions tried without lock
//     slip_cnt_o  out  [2:0] current slip position, modulo 8
//
//   state  | meaning
//   IDLE   | one cycle after reset before the first settle window
//   SETTLE | waiting SETTLE_CYCLES for the deserializer output to settle
//   CHECK  | comparing data_i against TRAIN_PATTERN, counting matches
//   SLIP   | bitslip_o high for one cycle, position advances
//   LOCKED | alignment found, data_o is valid
//   FAIL   | all eight positions missed; flag it and keep scanning
module bitslip_align
    import bitslip_align_pkg::*;
#(
    parameter logic [7:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
    parameter int         SETTLE_CYCLES = 3,
    parameter int         MATCH_COUNT   = 4,
    parameter int         MISS_LIMIT    = 4
) (
    input  logic       CLKDIV,
    input  logic       RST_N,
    input  logic [7:0] data_i,
    input  logic       realign_i,
    output logic       bitslip_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [2:0] slip_cnt_o
);

    generate
        if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 15 ||
            MATCH_COUNT   < 1 || MATCH_COUNT   > 15 ||
            MISS_LIMIT    < 1 || MISS_LIMIT    > 15) begin : g_param_err
            $error("bitslip_align: parameter out of range");
        end
    endgenerate

    // Settle timer is a down-counter loaded on entry; CHECK starts at zero.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MATCH_LAST  = CNT_W'(MATCH_COUNT - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] match_cnt;
    logic [2:0]       slip_cnt;
    logic             fail_q;
    logic             pattern_hit;

`ifdef BITSLIP_ALIGN_LOCK_MON_EN
    localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_LIMIT - 1);
    logic [CNT_W-1:0] miss_cnt;
`endif

    assign pattern_hit = (data_i == TRAIN_PATTERN);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   state_nx = SETTLE;
            SETTLE: if (settle_cnt == '0) state_nx = CHECK;
            CHECK: begin
                if (pattern_hit) begin
                    if (match_cnt == MATCH_LAST) state_nx = LOCKED;
                end else if (slip_cnt == 3'd7) begin
                    state_nx = FAIL;
                end else begin
                    state_nx = SLIP;
                end
            end
            SLIP:   state_nx = SETTLE;
            LOCKED: begin
`ifdef BITSLIP_ALIGN_LOCK_MON_EN
                if (!pattern_hit && miss_cnt == MISS_LAST) state_nx = SLIP;
`endif
            end
            FAIL:   state_nx = SLIP;
            default: state_nx = IDLE;
        endcase
        // Realign overrides everything, including lock completion.
        if (realign_i) state_nx = SETTLE;
    end

    always_ff @(posedge CLKDIV) begin
        if (!RST_N) begin
            state      <= IDLE;
            settle_cnt <= '0;
            match_cnt  <= '0;
            slip_cnt   <= '0;
            fail_q     <= 1'b0;
            valid_o    <= 1'b0;
            data_o     <= 8'h00;
`ifdef BITSLIP_ALIGN_LOCK_MON_EN
            miss_cnt   <= '0;
`endif
        end else begin
            state   <= state_nx;
            data_o  <= data_i;
            valid_o <= (state_nx == LOCKED);

            if (state_nx == SETTLE && (state != SETTLE || realign_i))
                settle_cnt <= SETTLE_LOAD;
            else if (state == SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;

            if (state == CHECK && !realign_i && pattern_hit)
                match_cnt <= match_cnt + 1'b1;
            else
                match_cnt <= '0;

            // The slip out of FAIL takes position 7 back round to 0, which
            // FAIL has already recorded, so that slip does not count again.
            if (realign_i || state_nx == FAIL)
                slip_cnt <= 3'd0;
            else if (state_nx == SLIP && state != FAIL)
                slip_cnt <= slip_cnt + 3'd1;

            if (realign_i || state_nx == LOCKED)
                fail_q <= 1'b0;
            else if (state_nx == FAIL)
                fail_q <= 1'b1;

`ifdef BITSLIP_ALIGN_LOCK_MON_EN
            if (state == LOCKED && state_nx == LOCKED && !pattern_hit)
                miss_cnt <= miss_cnt + 1'b1;
            else
                miss_cnt <= '0;
`endif
        end
    end

    assign bitslip_o  = (state == SLIP);
    assign locked_o   = (state == LOCKED);
    assign fail_o     = fail_q;
    assign slip_cnt_o = slip_cnt;

endmodule

// File: tb/tb_bitslip_align.sv
// tb_bitslip_align
//   Bench for bitslip_align with a deserializer model: the presented word is
//   TRAIN_PATTERN rotated by (8 - offset + slips) mod 8, where each bitslip
//   pulse takes effect at the clock edge that samples it.
//   Define BITSLIP_ALIGN_LOCK_MON_EN for both files to exercise lock monitoring.
module tb_bitslip_align;
    import bitslip_align_pkg::*;

    logic       CLKDIV = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       realign_i = 1'b0;
    logic       bitslip_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       locked_o;
    logic       fail_o;
    logic [2:0] slip_cnt_o;

    always #5 CLKDIV = ~CLKDIV;

    bitslip_align dut (
        .CLKDIV     (CLKDIV),
        .RST_N      (RST_N),
        .data_i     (data_i),
        .realign_i  (realign_i),
        .bitslip_o  (bitslip_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .locked_o   (locked_o),
        .fail_o     (fail_o),
        .slip_cnt_o (slip_cnt_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = -100;

    int offset = 0;
    int pos = 0;
    bit slip_prev = 1'b0;
    bit force_bad = 1'b0;
    bit const_zero = 1'b0;

    logic [7:0] data_q[$];
    logic [2:0] slip_q[$];

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        int k;
        k = n % 8;
        return (k == 0) ? v : ((v << k) | (v >> (8 - k)));
    endfunction

    function automatic logic [7:0] model_word();
        if (const_zero || force_bad) return 8'h00;
        return rotl8(8'hF0, (8 - offset + (pos % 8)) % 8);
    endfunction

    // One clock: drive data, push expected data_o, sample #1 after the edge.
    task automatic tick();
        logic [7:0] exp_d;
        logic [2:0] exp_s;
        data_i = model_word();
        data_q.push_back(RST_N ? data_i : 8'h00);
        @(posedge CLKDIV);
        #1;
        cyc++;
        if (slip_prev) pos++;
        slip_prev = bitslip_o;
        exp_d = data_q.pop_front();
        checks++;
        if (data_o !== exp_d) begin
            errors++;
            $display("FAIL data_o cyc=%0d: got %02h expected %02h", cyc, data_o, exp_d);
        end
        if (bitslip_o) begin
            pulses++;
            checks++;
            if (cyc - last_pulse < 5) begin
                errors++;
                $display("FAIL pulse_gap cyc=%0d: got %0d expected >=5", cyc, cyc - last_pulse);
            end
            last_pulse = cyc;
            if (slip_q.size() > 0) begin
                exp_s = slip_q.pop_front();
                checks++;
                if (slip_cnt_o !== exp_s) begin
                    errors++;
                    $display("FAIL slip_cnt_at_pulse cyc=%0d: got %0d expected %0d", cyc, slip_cnt_o, exp_s);
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        RST_N = 1'b0;
        realign_i = 1'b0;
        slip_q.delete();
        repeat (n) tick();
    endtask

    task automatic wait_lock(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (locked_o) begin
                ok = 1'b1;
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        offset = 0; pos = 0; slip_prev = 0;
        do_reset(3);
        checks++;
        if ({bitslip_o, locked_o, valid_o, fail_o, slip_cnt_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got b%b l%b v%b f%b s%0d expected all 0",
                     bitslip_o, locked_o, valid_o, fail_o, slip_cnt_o);
        end
    endtask

    task automatic test_offset3();
        bit ok; int n; int p0;
        offset = 3; pos = 0; slip_prev = 0;
        do_reset(2);
        slip_q = '{3'd1, 3'd2, 3'd3};
        p0 = pulses;
        RST_N = 1'b1;
        wait_lock(200, ok, n);
        checks++;
        if (!ok || n != 23) begin
            errors++;
            $display("FAIL off3_lock_time: got ok=%0d n=%0d expected n=23", ok, n);
        end
        checks++;
        if (pulses - p0 != 3) begin
            errors++;
            $display("FAIL off3_pulses: got %0d expected 3", pulses - p0);
        end
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'hF0) begin
            errors++;
            $display("FAIL off3_first_valid: got v=%b d=%02h expected v=1 d=f0", valid_o, data_o);
        end
        checks++;
        if (slip_cnt_o !== 3'd3 || fail_o !== 1'b0) begin
            errors++;
            $display("FAIL off3_status: got s=%0d f=%b expected s=3 f=0", slip_cnt_o, fail_o);
        end
        checks++;
        if (slip_q.size() != 0) begin
            errors++;
            $display("FAIL off3_slip_queue: got %0d left expected 0", slip_q.size());
        end
        repeat (3) tick();
        checks++;
        if (locked_o !== 1'b1) begin
            errors++;
            $display("FAIL off3_hold: got locked=%b expected 1", locked_o);
        end
    endtask

    task automatic test_realign();
        bit ok; int n; int p0;
        realign_i = 1'b1;
        offset = 3; pos = 0; slip_prev = 0;
        tick();
        realign_i = 1'b0;
        checks++;
        if ({locked_o, valid_o, fail_o, bitslip_o, slip_cnt_o} !== 7'b0) begin
            errors++;
            $display("FAIL realign_clear: got l%b v%b f%b b%b s%0d expected all 0",
                     locked_o, valid_o, fail_o, bitslip_o, slip_cnt_o);
        end
        slip_q = '{3'd1, 3'd2, 3'd3};
        p0 = pulses;
        wait_lock(200, ok, n);
        checks++;
        if (!ok || n != 22 || slip_cnt_o !== 3'd3 || pulses - p0 != 3) begin
            errors++;
            $display("FAIL realign_relock: got ok=%0d n=%0d s=%0d p=%0d expected n=22 s=3 p=3",
                     ok, n, slip_cnt_o, pulses - p0);
        end
    endtask

    task automatic test_realign_on_lock();
        int p0;
        offset = 0; pos = 0; slip_prev = 0;
        do_reset(2);
        p0 = pulses;
        RST_N = 1'b1;
        repeat (7) tick();
        checks++;
        if (locked_o !== 1'b0) begin
            errors++;
            $display("FAIL rol_pre: got locked=%b expected 0", locked_o);
        end
        realign_i = 1'b1;
        tick();
        realign_i = 1'b0;
        checks++;
        if (locked_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rol_blocked: got l=%b v=%b expected 0 0", locked_o, valid_o);
        end
        repeat (6) tick();
        checks++;
        if (locked_o !== 1'b0) begin
            errors++;
            $display("FAIL rol_settle: got locked=%b expected 0", locked_o);
        end
        tick();
        checks++;
        if (locked_o !== 1'b1 || valid_o !== 1'b1 || pulses != p0) begin
            errors++;
            $display("FAIL rol_relock: got l=%b v=%b p=%0d expected 1 1 0",
                     locked_o, valid_o, pulses - p0);
        end
    endtask

    task automatic test_fail();
        int n; int p0; bit seen;
        const_zero = 1'b1; offset = 0; pos = 0; slip_prev = 0;
        do_reset(2);
        slip_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        p0 = pulses;
        RST_N = 1'b1;
        seen = 1'b0; n = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (fail_o) begin
                seen = 1'b1; n = i;
                break;
            end
        end
        checks++;
        if (!seen || n != 40) begin
            errors++;
            $display("FAIL fail_time: got seen=%0d n=%0d expected n=40", seen, n);
        end
        checks++;
        if (pulses - p0 != 7 || slip_cnt_o !== 3'd0 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL fail_state: got p=%0d s=%0d l=%b expected p=7 s=0 l=0",
                     pulses - p0, slip_cnt_o, locked_o);
        end
        tick();
        checks++;
        if (bitslip_o !== 1'b1 || fail_o !== 1'b1) begin
            errors++;
            $display("FAIL fail_rescan: got b=%b f=%b expected 1 1", bitslip_o, fail_o);
        end
        repeat (5) tick();
        checks++;
        if (pulses - p0 != 9 || fail_o !== 1'b1 || locked_o !== 1'b0 || slip_q.size() != 0) begin
            errors++;
            $display("FAIL fail_continue: got p=%0d f=%b l=%b q=%0d expected p=9 f=1 l=0 q=0",
                     pulses - p0, fail_o, locked_o, slip_q.size());
        end
        const_zero = 1'b0;
    endtask

    task automatic test_lock_mon();
        bit ok; int n; int p0;
        offset = 0; pos = 0; slip_prev = 0;
        do_reset(2);
        RST_N = 1'b1;
        wait_lock(50, ok, n);
        checks++;
        if (!ok || n != 8) begin
            errors++;
            $display("FAIL mon_lock: got ok=%0d n=%0d expected n=8", ok, n);
        end
        force_bad = 1'b1;
        repeat (3) tick();
        force_bad = 1'b0;
        checks++;
        if (locked_o !== 1'b1) begin
            errors++;
            $display("FAIL mon_three_miss: got locked=%b expected 1", locked_o);
        end
        tick();
        force_bad = 1'b1;
        p0 = pulses;
`ifdef BITSLIP_ALIGN_LOCK_MON_EN
        slip_q.push_back(3'd1);
        repeat (4) tick();
        checks++;
        if (locked_o !== 1'b0 || valid_o !== 1'b0 || bitslip_o !== 1'b1 || pulses - p0 != 1) begin
            errors++;
            $display("FAIL mon_four_miss: got l=%b v=%b b=%b p=%0d expected 0 0 1 1",
                     locked_o, valid_o, bitslip_o, pulses - p0);
        end
`else
        repeat (4) tick();
        checks++;
        if (locked_o !== 1'b1 || valid_o !== 1'b1 || pulses != p0) begin
            errors++;
            $display("FAIL nomon_four_miss: got l=%b v=%b p=%0d expected 1 1 0",
                     locked_o, valid_o, pulses - p0);
        end
`endif
        force_bad = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        bit ok; bit seen; int n; int p0;
        offset = 3; pos = 0; slip_prev = 0;
        do_reset(2);
        RST_N = 1'b1;
        repeat (2) tick();
        p0 = pulses;
        RST_N = 1'b0;
        tick();
        checks++;
        if ({bitslip_o, locked_o, valid_o, fail_o, slip_cnt_o} !== 7'b0 || data_o !== 8'h00) begin
            errors++;
            $display("FAIL rst_settle: got b%b l%b v%b f%b s%0d d%02h expected all 0",
                     bitslip_o, locked_o, valid_o, fail_o, slip_cnt_o, data_o);
        end
        repeat (8) tick();
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL rst_settle_pulses: got %0d expected 0", pulses - p0);
        end
        slip_q = '{3'd1};
        RST_N = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bitslip_o) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_slip_find: got no pulse expected one");
        end
        RST_N = 1'b0;
        p0 = pulses;
        repeat (8) tick();
        checks++;
        if (pulses != p0 || locked_o !== 1'b0 || slip_cnt_o !== 3'd0) begin
            errors++;
            $display("FAIL rst_slip_abort: got p=%0d l=%b s=%0d expected 0 0 0",
                     pulses - p0, locked_o, slip_cnt_o);
        end
        slip_q = '{3'd1, 3'd2};
        RST_N = 1'b1;
        wait_lock(200, ok, n);
        checks++;
        if (!ok || n != 18 || slip_cnt_o !== 3'd2) begin
            errors++;
            $display("FAIL rst_restart: got ok=%0d n=%0d s=%0d expected n=18 s=2", ok, n, slip_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_offset3();
        test_realign();
        test_realign_on_lock();
        test_fail();
        test_lock_mon();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
